legv8_control_sequencer: RTL and testbench

- Multi-cycle control unit for the 64-bit LEGv8 datapath. Sits directly upstream of the datapath.
- Consumes the fetched 32-bit instruction and the registered 4-bit status, and produces the full control word each cycle: register selects, ALU function, bus enables, PC control and RAM strobes.
- Supports ADD, SUB, ADDI, LDUR, STUR, B, CBZ and HALT.
- Stops in a halt state and flags unrecognised opcodes.

---
 rtl/legv8_control_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_legv8_control_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_sequencer.sv
// LEGv8 multi-cycle control sequencer: latches the fetched instruction and
// drives the datapath control word through FETCH/EXEC/MEM/BRCHK/HALT.
module legv8_control_sequencer #(
   parameter logic [4:0] FS_ADD  = 5'b01000,
   parameter logic [4:0] FS_SUB  = 5'b01001,
   parameter logic [1:0] PS_HOLD = 2'b00,
   parameter logic [1:0] PS_INC  = 2'b01,
   parameter logic [1:0] PS_BR   = 2'b11,
   parameter logic [1:0] ZBIT    = 2'd0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        run,
   input  logic [31:0] inst,
   input  logic [3:0]  PRESTAT,
   output logic [4:0]  SA,
   output logic [4:0]  SB,
   output logic [4:0]  DA,
   output logic [4:0]  FS,
   output logic [63:0] K,
   output logic        WR,
   output logic        C0,
   output logic        M,
   output logic        SFL,
   output logic        EN_ALU,
   output logic        EN_ADDR_ALU,
   output logic        EN_B,
   output logic        EN_PC,
   output logic        EN_ADDR_PC,
   output logic        PC_SEL,
   output logic        BR_SEL,
   output logic [1:0]  PS,
   output logic        RCS,
   output logic        RWE,
   output logic        ROE,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] icount
);

   typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_BRCHK, S_HALT} state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_ADDI, OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_HALT, OP_ILL
   } op_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_ir;
   logic        r_illegal;
   logic [15:0] r_icount;
   op_t         w_op;
   logic        w_retire;
   logic        w_set_ill;
   logic        w_wr;
   logic [4:0]  w_rd;
   logic [4:0]  w_rn;
   logic [4:0]  w_rm;
   logic        w_unused;

   assign w_rd     = r_ir[4:0];
   assign w_rn     = r_ir[9:5];
   assign w_rm     = r_ir[20:16];
   assign w_unused = ^PRESTAT;

   always_comb begin
      w_op = OP_ILL;
      if (r_ir == '0)                              w_op = OP_HALT;
      else if (r_ir[31:21] == 11'b10001011000)     w_op = OP_ADD;
      else if (r_ir[31:21] == 11'b11001011000)     w_op = OP_SUB;
      else if (r_ir[31:22] == 10'b1001000100)      w_op = OP_ADDI;
      else if (r_ir[31:21] == 11'b11111000010)     w_op = OP_LDUR;
      else if (r_ir[31:21] == 11'b11111000000)     w_op = OP_STUR;
      else if (r_ir[31:26] == 6'b000101)           w_op = OP_B;
      else if (r_ir[31:24] == 8'b10110100)         w_op = OP_CBZ;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_FETCH;
         r_ir      <= '0;
         r_illegal <= 1'b0;
         r_icount  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && run) r_ir <= inst;
         if (w_set_ill) r_illegal <= 1'b1;
         if (w_retire)  r_icount  <= r_icount + 16'd1;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_retire    = 1'b0;
      w_set_ill   = 1'b0;
      w_wr        = 1'b0;
      SA          = '0;
      SB          = '0;
      DA          = '0;
      FS          = '0;
      K           = '0;
      C0          = 1'b0;
      M           = 1'b0;
      SFL         = 1'b0;
      EN_ALU      = 1'b0;
      EN_ADDR_ALU = 1'b0;
      EN_B        = 1'b0;
      EN_PC       = 1'b0;
      EN_ADDR_PC  = 1'b0;
      PC_SEL      = 1'b0;
      BR_SEL      = 1'b0;
      PS          = PS_HOLD;
      RCS         = 1'b0;
      RWE         = 1'b0;
      ROE         = 1'b0;

      // Rn + simm9 address path; MEM repeats it so the RAM address stays stable
      if (r_state == S_MEM ||
          (r_state == S_EXEC && (w_op == OP_LDUR || w_op == OP_STUR))) begin
         SA          = w_rn;
         M           = 1'b1;
         K           = {{55{r_ir[20]}}, r_ir[20:12]};
         FS          = FS_ADD;
         EN_ADDR_ALU = 1'b1;
         RCS         = 1'b1;
      end

      case (r_state)
         S_FETCH: if (run) w_next = S_EXEC;
         S_EXEC: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
            case (w_op)
               OP_ADD, OP_SUB: begin
                  SA     = w_rn;
                  SB     = w_rm;
                  DA     = w_rd;
                  FS     = (w_op == OP_SUB) ? FS_SUB : FS_ADD;
                  C0     = (w_op == OP_SUB);
                  EN_ALU = 1'b1;
                  w_wr   = 1'b1;
                  SFL    = 1'b1;
                  PS     = PS_INC;
               end
               OP_ADDI: begin
                  SA     = w_rn;
                  DA     = w_rd;
                  M      = 1'b1;
                  K      = {52'd0, r_ir[21:10]};
                  FS     = FS_ADD;
                  EN_ALU = 1'b1;
                  w_wr   = 1'b1;
                  PS     = PS_INC;
               end
               OP_LDUR: begin
                  ROE      = 1'b1;
                  w_retire = 1'b0;
                  w_next   = S_MEM;
               end
               OP_STUR: begin
                  SB   = w_rd;
                  EN_B = 1'b1;
                  RWE  = 1'b1;
                  PS   = PS_INC;
               end
               OP_B: begin
                  K      = {{38{r_ir[25]}}, r_ir[25:0]};
                  BR_SEL = 1'b1;
                  PC_SEL = 1'b1;
                  PS     = PS_BR;
               end
               OP_CBZ: begin
                  SA       = r_ir[4:0];
                  M        = 1'b1;
                  FS       = FS_ADD;
                  SFL      = 1'b1;
                  w_retire = 1'b0;
                  w_next   = S_BRCHK;
               end
               OP_HALT: begin
                  w_retire = 1'b0;
                  w_next   = S_HALT;
               end
               default: begin
                  PS        = PS_INC;
                  w_set_ill = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            ROE      = 1'b1;
            DA       = w_rd;
            w_wr     = 1'b1;
            PS       = PS_INC;
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_BRCHK: begin
            K = {{45{r_ir[23]}}, r_ir[23:5]};
            if (PRESTAT[ZBIT]) begin
               BR_SEL = 1'b1;
               PC_SEL = 1'b1;
               PS     = PS_BR;
            end else begin
               PS = PS_INC;
            end
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase
   end

   // X31 reads as XZR, so a write to it is dropped
   assign WR      = w_wr & (DA != 5'd31);
   assign halted  = (r_state == S_HALT);
   assign illegal = r_illegal;
   assign icount  = r_icount;

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// Randomized self-checking bench for legv8_control_sequencer against a
// per-instruction control-word sequence model.
module tb_legv8_control_sequencer;

   localparam logic [4:0] FS_ADD  = 5'b01000;
   localparam logic [4:0] FS_SUB  = 5'b01001;
   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_BR   = 2'b11;

   logic        CLK = 1'b0;
   logic        RST;
   logic        run;
   logic [31:0] inst;
   logic [3:0]  PRESTAT;
   logic [4:0]  SA, SB, DA, FS;
   logic [63:0] K;
   logic        WR, C0, M, SFL;
   logic        EN_ALU, EN_ADDR_ALU, EN_B, EN_PC, EN_ADDR_PC;
   logic        PC_SEL, BR_SEL;
   logic [1:0]  PS;
   logic        RCS, RWE, ROE;
   logic        halted, illegal;
   logic [15:0] icount;

   legv8_control_sequencer dut (
      .CLK(CLK), .RST(RST), .run(run), .inst(inst), .PRESTAT(PRESTAT),
      .SA(SA), .SB(SB), .DA(DA), .FS(FS), .K(K),
      .WR(WR), .C0(C0), .M(M), .SFL(SFL),
      .EN_ALU(EN_ALU), .EN_ADDR_ALU(EN_ADDR_ALU), .EN_B(EN_B), .EN_PC(EN_PC),
      .EN_ADDR_PC(EN_ADDR_PC), .PC_SEL(PC_SEL), .BR_SEL(BR_SEL), .PS(PS),
      .RCS(RCS), .RWE(RWE), .ROE(ROE),
      .halted(halted), .illegal(illegal), .icount(icount)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [4:0]  sa, sb, da, fs;
      logic [63:0] k;
      logic        wr, c0, m, sfl;
      logic        en_alu, en_addr_alu, en_b, en_pc, en_addr_pc;
      logic        pc_sel, br_sel;
      logic [1:0]  ps;
      logic        rcs, rwe, roe;
   } cw_t;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   int unsigned m_icount;
   logic        m_ill;
   cw_t         exp_q[$];

   // Opcode patterns: ADD, SUB, ADDI, LDUR, STUR, B, CBZ
   logic [31:0] pat_mask [7] = '{32'hFFE00000, 32'hFFE00000, 32'hFFC00000,
                                 32'hFFE00000, 32'hFFE00000, 32'hFC000000, 32'hFF000000};
   logic [31:0] pat_val  [7] = '{32'h8B000000, 32'hCB000000, 32'h91000000,
                                 32'hF8400000, 32'hF8000000, 32'h14000000, 32'hB4000000};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic cw_t cur_cw();
      cw_t c;
      c.sa = SA; c.sb = SB; c.da = DA; c.fs = FS; c.k = K;
      c.wr = WR; c.c0 = C0; c.m = M; c.sfl = SFL;
      c.en_alu = EN_ALU; c.en_addr_alu = EN_ADDR_ALU; c.en_b = EN_B;
      c.en_pc = EN_PC; c.en_addr_pc = EN_ADDR_PC;
      c.pc_sel = PC_SEL; c.br_sel = BR_SEL; c.ps = PS;
      c.rcs = RCS; c.rwe = RWE; c.roe = ROE;
      return c;
   endfunction

   // 0..6 per pattern table, 7 = HALT, 8 = unrecognised
   function automatic int unsigned classify(input logic [31:0] ins);
      if (ins == 32'h0) return 7;
      for (int i = 0; i < 7; i++)
         if ((ins & pat_mask[i]) == pat_val[i]) return i;
      return 8;
   endfunction

   function automatic logic [63:0] field(input logic [31:0] ins, input int unsigned hi,
                                         input int unsigned lo);
      logic [31:0] msk;
      msk = (32'd1 << (hi - lo + 1)) - 32'd1;
      return 64'((ins >> lo) & msk);
   endfunction

   function automatic logic [63:0] sx(input logic [63:0] v, input int unsigned n);
      return v[n-1] ? v - (64'd1 << n) : v;
   endfunction

   task automatic build_expect(input logic [31:0] ins, input logic zf,
                               output logic ret, output logic ill);
      cw_t a, b;
      logic [4:0] rd;
      rd = 5'(field(ins, 4, 0));
      exp_q.delete();
      a = '0; ret = 1'b1; ill = 1'b0;
      case (classify(ins))
         0, 1: begin
            a.sa = 5'(field(ins, 9, 5)); a.sb = 5'(field(ins, 20, 16)); a.da = rd;
            a.fs = (classify(ins) == 1) ? FS_SUB : FS_ADD;
            a.c0 = (classify(ins) == 1);
            a.en_alu = 1'b1; a.wr = (rd != 5'd31); a.sfl = 1'b1; a.ps = PS_INC;
            exp_q.push_back(a);
         end
         2: begin
            a.sa = 5'(field(ins, 9, 5)); a.da = rd; a.m = 1'b1; a.k = field(ins, 21, 10);
            a.fs = FS_ADD; a.en_alu = 1'b1; a.wr = (rd != 5'd31); a.ps = PS_INC;
            exp_q.push_back(a);
         end
         3, 4: begin
            a.sa = 5'(field(ins, 9, 5)); a.m = 1'b1; a.k = sx(field(ins, 20, 12), 9);
            a.fs = FS_ADD; a.en_addr_alu = 1'b1; a.rcs = 1'b1;
            if (classify(ins) == 3) begin
               a.roe = 1'b1;
               b = a; b.da = rd; b.wr = (rd != 5'd31); b.ps = PS_INC;
               exp_q.push_back(a);
               exp_q.push_back(b);
            end else begin
               a.sb = rd; a.en_b = 1'b1; a.rwe = 1'b1; a.ps = PS_INC;
               exp_q.push_back(a);
            end
         end
         5: begin
            a.k = sx(field(ins, 25, 0), 26); a.br_sel = 1'b1; a.pc_sel = 1'b1; a.ps = PS_BR;
            exp_q.push_back(a);
         end
         6: begin
            a.sa = rd; a.m = 1'b1; a.fs = FS_ADD; a.sfl = 1'b1;
            b = '0; b.k = sx(field(ins, 23, 5), 19);
            if (zf) begin b.br_sel = 1'b1; b.pc_sel = 1'b1; b.ps = PS_BR; end
            else b.ps = PS_INC;
            exp_q.push_back(a);
            exp_q.push_back(b);
         end
         7: begin
            exp_q.push_back(a);
            ret = 1'b0;
         end
         default: begin
            a.ps = PS_INC; ill = 1'b1;
            exp_q.push_back(a);
         end
      endcase
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic zf, input logic drop_run);
      logic ret, ill;
      build_expect(ins, zf, ret, ill);
      @(negedge CLK);
      inst = ins; run = 1'b1; PRESTAT = {3'($urandom()), zf};
      #1 check("fetch_cw", 128'(cur_cw()), '0);
      @(posedge CLK); #1;
      inst = $urandom();
      if (drop_run) run = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge CLK);
         check($sformatf("cw_%h_c%0d", ins, i), 128'(cur_cw()), 128'(exp_q[i]));
         check("bus_excl", 128'($countones({EN_ALU, EN_B, EN_PC}) <= 1 &&
                                !(EN_ADDR_ALU && EN_ADDR_PC)), 128'(1));
         if (i == exp_q.size() - 1) run = 1'b0;
         @(posedge CLK); #1;
      end
      if (ret) m_icount++;
      if (ill) m_ill = 1'b1;
      @(negedge CLK);
      check("icount", 128'(icount), 128'(m_icount & 32'hFFFF));
      check("illegal", 128'(illegal), 128'(m_ill));
      check("idle_cw", 128'(cur_cw()), '0);
      check("halted", 128'(halted), '0);
   endtask

   task automatic idle(input int unsigned n);
      run = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge CLK);
         inst = $urandom(); PRESTAT = 4'($urandom());
         #1 check("stall_cw", 128'(cur_cw()), '0);
         check("stall_icount", 128'(icount), 128'(m_icount & 32'hFFFF));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] ins;
      int unsigned c;
      RST = 1'b1; run = 1'b0; inst = '0; PRESTAT = '0;
      m_icount = 0; m_ill = 1'b0;
      #2 RST = 1'b0;
      #1;
      check("rst_cw", 128'(cur_cw()), '0);
      check("rst_halted", 128'(halted), '0);
      check("rst_illegal", 128'(illegal), '0);
      check("rst_icount", 128'(icount), '0);
      #9 RST = 1'b1;

      run_instr(32'h8B020023, 1'b0, 1'b0);
      run_instr(32'hF8408045, 1'b0, 1'b0);
      run_instr(32'hB4000084, 1'b1, 1'b0);
      run_instr(32'hB4000084, 1'b0, 1'b0);
      run_instr(32'hFFFFFFFF, 1'b0, 1'b0);
      run_instr(32'h8B020023, 1'b0, 1'b0);
      idle(5);
      run_instr(32'hF8008045, 1'b0, 1'b1);
      run_instr(32'h8B1F03FF, 1'b0, 1'b0);
      run_instr(32'h17FFFFFF, 1'b0, 1'b0);

      for (int n = 0; n < 250; n++) begin
         c = $urandom_range(0, 7);
         if (c == 7) begin
            ins = $urandom();
            for (int t = 0; t < 100 && classify(ins) != 8; t++) ins = $urandom();
         end else begin
            ins = ($urandom() & ~pat_mask[c]) | pat_val[c];
         end
         run_instr(ins, 1'($urandom()), 1'($urandom()));
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end

      @(negedge CLK);
      inst = 32'h0; run = 1'b1;
      @(posedge CLK); #1;
      inst = $urandom();
      @(negedge CLK);
      check("halt_exec_cw", 128'(cur_cw()), '0);
      check("halt_exec_flag", 128'(halted), '0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("halt_flag", 128'(halted), 128'(1));
         check("halt_cw", 128'(cur_cw()), '0);
         check("halt_icount", 128'(icount), 128'(m_icount & 32'hFFFF));
      end
      #2 RST = 1'b0;
      #1;
      check("halt_rst_flag", 128'(halted), '0);
      check("halt_rst_icount", 128'(icount), '0);
      check("halt_rst_illegal", 128'(illegal), '0);
      check("halt_rst_cw", 128'(cur_cw()), '0);
      m_icount = 0; m_ill = 1'b0; run = 1'b0;
      @(negedge CLK) RST = 1'b1;
      run_instr(32'h8B020023, 1'b0, 1'b0);

      @(negedge CLK);
      inst = 32'hF8408045; run = 1'b1;
      @(posedge CLK); #1;
      run = 1'b0;
      @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      check("midinst_rst_cw", 128'(cur_cw()), '0);
      check("midinst_rst_icount", 128'(icount), '0);
      m_icount = 0;
      @(negedge CLK) RST = 1'b1;
      run_instr(32'hCB030041, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
